// File: rtl/lc4_pipe_pkg.sv
// Shared LC4 pipeline types and constants: F/D stall codes, NOP word, reset PC.
package lc4_pipe_pkg;

  typedef enum logic [1:0] {
    STALL_NONE     = 2'd0,
    STALL_FLUSH    = 2'd2,
    STALL_LOAD_USE = 2'd3
  } stall_code_t;

  localparam logic [15:0] LC4_NOP      = 16'h0000;
  localparam logic [15:0] LC4_RESET_PC = 16'h8200;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pc_plus_one;
    logic [15:0] insn;
    stall_code_t code;
  } fd_t;

endpackage

// File: rtl/lc4_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module lc4_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/lc4_fetch_stage.sv
// LC4 fetch stage: PC register, F/D boundary register with stall/flush
// handling, and fetch/bubble performance counters.
module lc4_fetch_stage
  import lc4_pipe_pkg::*;
#(
  parameter logic [15:0] RESET_PC = LC4_RESET_PC,
  parameter logic [15:0] NOP_INSN = LC4_NOP,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  output logic [15:0]      o_imem_addr,
  input  logic [15:0]      i_imem_data,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [15:0]      i_redirect_pc,
  output logic [15:0]      o_cur_pc,
  output logic [15:0]      o_cur_pc_plus_one,
  output logic [15:0]      o_cur_insn,
  output logic [1:0]       o_stall_code,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_fetch_count,
  output logic [CNT_W-1:0] o_bubble_count
);

  localparam fd_t FD_BUBBLE = '{pc: 16'h0000, pc_plus_one: 16'h0000,
                                insn: NOP_INSN, code: STALL_FLUSH};

  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  fd_t         fd;
  logic        fetch_inc;
  logic        bubble_inc;

  assign pc_next_seq = pc + 16'd1;

  // Redirect outranks stall; stall freezes both PC and F/D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      fd <= FD_BUBBLE;
    end else if (gwe) begin
      if (i_redirect) begin
        pc <= i_redirect_pc;
        fd <= FD_BUBBLE;
      end else if (!i_stall) begin
        pc <= pc_next_seq;
        fd <= '{pc: pc, pc_plus_one: pc_next_seq, insn: i_imem_data,
                code: STALL_NONE};
      end
    end
  end

  assign fetch_inc  = gwe & ~i_redirect & ~i_stall;
  assign bubble_inc = gwe & (i_redirect | i_stall);

  lc4_sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk(clk), .rst(rst), .en(fetch_inc), .count(o_fetch_count)
  );

  lc4_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .en(bubble_inc), .count(o_bubble_count)
  );

  assign o_imem_addr       = pc;
  assign o_cur_pc          = fd.pc;
  assign o_cur_pc_plus_one = fd.pc_plus_one;
  assign o_cur_insn        = fd.insn;
  assign o_stall_code      = fd.code;
  assign o_valid           = (fd.code == STALL_NONE);

endmodule

// File: tb/tb_lc4_fetch_stage.sv
// Directed bench for lc4_fetch_stage: vector table plus hand-written
// counter-saturation and asynchronous-reset sequences.
module tb_lc4_fetch_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          gwe;
  logic [15:0]   imem_addr;
  logic [15:0]   imem_data;
  logic          stall;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic [15:0]   cur_pc;
  logic [15:0]   cur_ppo;
  logic [15:0]   cur_insn;
  logic [1:0]    stall_code;
  logic          valid;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc4_fetch_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_cur_pc(cur_pc), .o_cur_pc_plus_one(cur_ppo), .o_cur_insn(cur_insn),
    .o_stall_code(stall_code), .o_valid(valid),
    .o_fetch_count(fetch_count), .o_bubble_count(bubble_count)
  );

  typedef struct packed {
    logic        gwe, stall, redir;
    logic [15:0] rpc, imem;
    logic [15:0] addr, pc, ppo, insn;
    logic [1:0]  code;
    logic        valid;
    logic [3:0]  fc, bc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("imem_addr", idx, imem_addr, v.addr);
    chk("cur_pc", idx, cur_pc, v.pc);
    chk("cur_pc_plus_one", idx, cur_ppo, v.ppo);
    chk("cur_insn", idx, cur_insn, v.insn);
    chk("stall_code", idx, {14'd0, stall_code}, {14'd0, v.code});
    chk("valid", idx, {15'd0, valid}, {15'd0, v.valid});
    chk("fetch_count", idx, {12'd0, fetch_count}, {12'd0, v.fc});
    chk("bubble_count", idx, {12'd0, bubble_count}, {12'd0, v.bc});
  endtask

  task automatic drive(input logic g, input logic s, input logic r,
                       input logic [15:0] rp, input logic [15:0] im);
    gwe = g; stall = s; redirect = r; redirect_pc = rp; imem_data = im;
  endtask

  initial begin
    vec_t rst_v;
    //          gwe   stall redir rpc       imem      addr      pc        ppo       insn      code  vld   fc    bc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 16'h8201, 16'h8200, 16'h8201, 16'h1111, 2'd0, 1'b1, 4'd1, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h2222, 16'h8202, 16'h8201, 16'h8202, 16'h2222, 2'd0, 1'b1, 4'd2, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h3333, 16'h8203, 16'h8202, 16'h8203, 16'h3333, 2'd0, 1'b1, 4'd3, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h4444, 16'h8203, 16'h8202, 16'h8203, 16'h3333, 2'd0, 1'b1, 4'd3, 4'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h4444, 16'h8203, 16'h8202, 16'h8203, 16'h3333, 2'd0, 1'b1, 4'd3, 4'd2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h4444, 16'h8204, 16'h8203, 16'h8204, 16'h4444, 2'd0, 1'b1, 4'd4, 4'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'h5555, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 2'd2, 1'b0, 4'd4, 4'd3};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h6666, 16'h0041, 16'h0040, 16'h0041, 16'h6666, 2'd0, 1'b1, 4'd5, 4'd3};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h6666, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2'd2, 1'b0, 4'd5, 4'd4};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h7777, 16'h0000, 16'hFFFF, 16'h0000, 16'h7777, 2'd0, 1'b1, 4'd6, 4'd4};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h8888, 16'h0001, 16'h0000, 16'h0001, 16'h8888, 2'd0, 1'b1, 4'd7, 4'd4};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h9999, 16'h0001, 16'h0000, 16'h0001, 16'h8888, 2'd0, 1'b1, 4'd7, 4'd4};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h9999, 16'h0001, 16'h0000, 16'h0001, 16'h8888, 2'd0, 1'b1, 4'd7, 4'd4};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h9999, 16'h0001, 16'h0000, 16'h0001, 16'h8888, 2'd0, 1'b1, 4'd7, 4'd4};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h9999, 16'h0001, 16'h0000, 16'h0001, 16'h8888, 2'd0, 1'b1, 4'd7, 4'd4};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'hAAAA, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'd2, 1'b0, 4'd7, 4'd5};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h0002, 16'h0001, 16'h0002, 16'hAAAA, 2'd0, 1'b1, 4'd8, 4'd5};
    rst_v    = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h8200, 16'h0000, 16'h0000, 16'h0000, 2'd2, 1'b0, 4'd0, 4'd0};

    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all(-1, rst_v);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].gwe, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].imem);
      @(posedge clk); #1;
      chk_all(i, vecs[i]);
    end

    // Fetch counter climbs from 8 and sticks at 15.
    for (int i = 0; i < 10; i++) begin
      int e;
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF);
      @(posedge clk); #1;
      e = (9 + i > 15) ? 15 : 9 + i;
      chk("fetch_count_sat", i, {12'd0, fetch_count}, 16'(e));
    end

    // Bubble counter climbs from 5 and sticks at 15 while stalled.
    for (int i = 0; i < 12; i++) begin
      int e;
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF);
      @(posedge clk); #1;
      e = (6 + i > 15) ? 15 : 6 + i;
      chk("bubble_count_sat", i, {12'd0, bubble_count}, 16'(e));
      chk("fetch_count_hold", i, {12'd0, fetch_count}, 16'd15);
    end

    // Asynchronous reset between edges during a stall.
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all(100, rst_v);
    @(posedge clk); #1;
    chk_all(101, rst_v);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'hC0DE);
    chk("post_reset_addr", 102, imem_addr, 16'h8200);
    @(posedge clk); #1;
    chk_all(103, '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hC0DE, 16'h8201, 16'h8200,
                   16'h8201, 16'hC0DE, 2'd0, 1'b1, 4'd1, 4'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc4_fetch_stage.md
Name: lc4_fetch_stage

Overview:
- Instruction-fetch stage of the LC4 five-stage pipeline.
- Owns the PC register, drives the instruction-memory address, and registers the fetched instruction, PC and PC+1 into the F/D boundary. That boundary feeds the decode stage and the downstream pipeline registers.
- Handles load-use stalls from hazard detection and control redirects from execute, inserting flush bubbles as required.
- Keeps fetch and bubble performance counters.

Parameters:
RESET_PC, 16'h8200, PC value loaded on reset
NOP_INSN, 16'h0000, instruction word placed in F/D on a bubble
CNT_W, 32, width of performance counters

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
gwe  input  1  global write enable; 0 freezes all state
o_imem_addr  output  16  instruction-memory address, always equal to the current PC
i_imem_data  input  16  instruction word returned combinationally for o_imem_addr
i_stall  input  1  load-use stall request from hazard detection
i_redirect  input  1  taken branch/control transfer resolved in execute
i_redirect_pc  input  16  redirect target, valid when i_redirect=1
o_cur_pc  output  16  F/D registered PC
o_cur_pc_plus_one  output  16  F/D registered PC+1
o_cur_insn  output  16  F/D registered instruction
o_stall_code  output  2  F/D stall code: 0 valid, 2 flush bubble, 3 load-use stall
o_valid  output  1  F/D holds a real instruction (stall code 0)
o_fetch_count  output  CNT_W  instructions accepted into F/D
o_bubble_count  output  CNT_W  cycles spent stalled or flushing

Behaviour:
- Reset (asynchronous, effective immediately, regardless of gwe):
  - pc = RESET_PC.
  - F/D: o_cur_pc = 0, o_cur_pc_plus_one = 0, o_cur_insn = NOP_INSN, o_stall_code = 2, o_valid = 0.
  - Both counters = 0.
- gwe = 0: no register changes at the clock edge. Inputs are ignored for that cycle.
- o_imem_addr is combinational from the pc register, with no added latency. Fetch-to-F/D latency is 1 cycle.
- Per-edge update when gwe = 1, in strict priority order:
  1. i_redirect = 1 (overrides i_stall):
     - pc <= i_redirect_pc.
     - F/D <= bubble: insn NOP_INSN, code 2, valid 0, o_cur_pc / o_cur_pc_plus_one = 0.
     - bubble_count += 1.
  2. i_stall = 1:
     - pc holds.
     - All F/D fields hold, so decode re-presents the same instruction. The stall code is not rewritten; code 3 is applied by D/X.
     - bubble_count += 1.
  3. Otherwise:
     - pc <= pc + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
     - F/D <= {pc, pc+1, i_imem_data, code 0, valid 1}.
     - fetch_count += 1.
- Redirect-target flush: a redirect kills only the F/D occupant. Flushing D/X is the responsibility of the consumer.
- Redirect to the current PC is legal: the same PC is refetched on the next cycle after one bubble.
- Counters saturate at all-ones and never wrap.
- i_redirect_pc is not checked for alignment or privilege; any 16-bit value is accepted.
- Reset asserted mid-stall or mid-redirect: reset wins immediately. The first fetch after deassertion is RESET_PC.
- No X propagation: i_imem_data is sampled only in case 3.

Decomposition:
- Shared package lc4_pipe_pkg holds:
  - the stall-code typedef (STALL_NONE = 2'd0, STALL_FLUSH = 2'd2, STALL_LOAD_USE = 2'd3);
  - the NOP constant;
  - the LC4 reset-PC constant.
- Natural sub-module: lc4_sat_counter (CNT_W-wide saturating counter with increment enable), instantiated twice.

Test Plan:
- Reset then 3 cycles, gwe = 1, imem returns 16'h1111/2222/3333:
  - o_imem_addr goes 8200→8201→8202→8203;
  - F/D shows pc 8200/8201/8202 with insn 1111/2222/3333, code 0;
  - fetch_count = 3.
- i_stall high for 2 cycles at pc 8203:
  - pc stays 8203;
  - F/D unchanged (pc 8202, insn 3333);
  - bubble_count += 2;
  - fetch resumes at 8203.
- i_redirect = 1 with i_redirect_pc = 16'h0040, i_stall = 1 in the same cycle:
  - next o_imem_addr = 0040;
  - F/D code 2, insn 0000, valid 0;
  - following cycle F/D pc = 0040.
- Redirect to 16'hFFFF, then 2 normal cycles:
  - F/D pc FFFF with pc_plus_one 0000, then pc 0000;
  - o_imem_addr goes FFFF→0000→0001.
- gwe = 0 for 4 cycles while toggling i_stall and i_redirect: all outputs and counters frozen.
- Assert rst asynchronously between edges during a stall:
  - outputs return to reset values before the next edge;
  - the first post-reset fetch address is 8200;
  - counters = 0.
